// File: rtl/nes_pkg.sv
// nes_pkg: shared types and constants for the OAM DMA engine and PPU register port
package nes_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} oam_dma_state_t;
  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
  localparam logic [2:0]  PPU_OAMDATA      = 3'd4;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA, copies page $P00-$PFF into PPU OAMDATA while holding the CPU.
// Define OAM_DMA_ALIGN_EN to insert the odd/even ALIGN cycle before the first read.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter logic [2:0]  OAMDATA_IDX  = PPU_OAMDATA
) (
  input  logic        clk,
  input  logic        nres_in,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic        cpu_rdy,
  output logic        ppu_reg_cs,
  output logic        ppu_we,
  output logic [2:0]  ppu_reg_addr,
  output logic [7:0]  ppu_wdata
);
  oam_dma_state_t state_q;
  logic [7:0] page_q, byte_cnt_q;
  logic       need_align;
`ifdef OAM_DMA_ALIGN_EN
  logic cyc_odd_q;
  assign need_align = ~cyc_odd_q;
`else
  assign need_align = 1'b0;
`endif
  always_ff @(posedge clk or negedge nres_in) begin
    if (!nres_in) begin
      state_q    <= S_IDLE;
      page_q     <= 8'h00;
      byte_cnt_q <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
      cyc_odd_q  <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_ALIGN_EN
      cyc_odd_q <= ~cyc_odd_q;
`endif
      case (state_q)
        S_IDLE: if (cpu_wr && cpu_addr == DMA_REG_ADDR) begin
          state_q    <= S_HALT;
          page_q     <= cpu_wdata;
          byte_cnt_q <= 8'h00;
        end
        S_HALT:  state_q <= need_align ? S_ALIGN : S_READ;
        S_ALIGN: state_q <= S_READ;
        S_READ:  state_q <= S_WRITE;
        S_WRITE: begin
          byte_cnt_q <= byte_cnt_q + 8'd1;
          state_q    <= (byte_cnt_q == 8'hFF) ? S_IDLE : S_READ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    cpu_rdy      = state_q == S_IDLE;
    dma_rd       = state_q == S_READ;
    ppu_we       = state_q == S_WRITE;
    ppu_reg_cs   = ppu_we;
    dma_active   = dma_rd || ppu_we;
    dma_addr     = dma_rd ? {page_q, byte_cnt_q} : 16'h0000;
    ppu_reg_addr = ppu_we ? OAMDATA_IDX : 3'd0;
    ppu_wdata    = ppu_we ? mem_rdata : 8'h00;
  end
endmodule
